// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main control FSM sequencing fetch/decode/execute/memory/writeback.
module mc_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            ext_zero,
    output logic [1:0]      pc_src,
    output logic [2:0]      alu_op,
    output logic            retire,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);
    typedef enum logic [ST_W-1:0] {
        IDLE   = ST_W'(0),
        FETCH  = ST_W'(1),
        DECODE = ST_W'(2),
        MEMADR = ST_W'(3),
        MEMRD  = ST_W'(4),
        MEMWB  = ST_W'(5),
        MEMWR  = ST_W'(6),
        REXE   = ST_W'(7),
        RWB    = ST_W'(8),
        BRANCH = ST_W'(9),
        IEXE   = ST_W'(10),
        IWB    = ST_W'(11),
        JUMP   = ST_W'(12)
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       imm_zx;
    logic [2:0] imm_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Logical immediates zero-extend; the ALU class is held through writeback.
    assign imm_zx = (op_q == OP_ANDI) || (op_q == OP_ORI);
    assign imm_op = (op_q == OP_ANDI) ? 3'b100 : (op_q == OP_ORI) ? 3'b101 : 3'b000;
    assign state  = state_q;

    always_comb begin
        state_d    = FETCH;
        op_d       = op_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 3'b000;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                op_d      = opcode;
                case (opcode)
                    OP_LW, OP_SW:            state_d = MEMADR;
                    OP_R:                    state_d = REXE;
                    OP_BEQ, OP_BNE:          state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = IEXE;
                    OP_J:                    state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        retire     = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            REXE: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                state_d   = RWB;
            end
            RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_src    = 2'b01;
                retire    = 1'b1;
                pc_write  = (op_q == OP_BNE) ? ~zero : zero;
            end
            IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_op;
                ext_zero  = imm_zx;
                state_d   = IWB;
            end
            IWB: begin
                reg_write = 1'b1;
                alu_op    = imm_op;
                ext_zero  = imm_zx;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction streams with random wait states checked against a per-instruction trace model.
module tb_mc_ctrl;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0c, ORI = 6'h0d, J = 6'h02, RT = 6'h00;

    logic       clk, rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, ext_zero, retire, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [18:0] outs;
    int n_cmp = 0, n_bad = 0;

    mc_ctrl #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_src(pc_src),
        .alu_op(alu_op), .retire(retire), .illegal_op(illegal_op), .state(state)
    );

    assign outs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, ext_zero, pc_src, alu_op, retire, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, J};
    endfunction

    // Expected output vector for one cycle, straight from the per-state output table.
    function automatic logic [18:0] exp_outs(input int st, input logic [5:0] op, input logic z, input logic rdy);
        logic pcw, io, mr, mw, irw, rd, m2r, rw, sa, ez, ret, ill;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pcw, io, mr, mw, irw, rd, m2r, rw, sa, ez, ret, ill} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            1:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
            2:  begin sb = 2'b11; ill = !legal(op); ret = !legal(op); end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin io = 1; mr = 1; end
            5:  begin m2r = 1; rw = 1; ret = 1; end
            6:  begin io = 1; mw = 1; ret = rdy; end
            7:  begin sa = 1; ao = 3'b010; end
            8:  begin rd = 1; rw = 1; ret = 1; end
            9:  begin sa = 1; ao = 3'b001; ps = 2'b01; ret = 1; pcw = (op == BNE) ? !z : z; end
            10, 11: begin
                ao = (op == ANDI) ? 3'b100 : (op == ORI) ? 3'b101 : 3'b000;
                ez = (op == ANDI) || (op == ORI);
                if (st == 10) begin sa = 1; sb = 2'b10; end
                else begin rw = 1; ret = 1; end
            end
            12: begin ps = 2'b10; pcw = 1; ret = 1; end
            default: ;
        endcase
        return {pcw, io, mr, mw, irw, rd, m2r, rw, sa, sb, ez, ps, ao, ret, ill};
    endfunction

    // One cycle: opcode bus only carries the real instruction during DECODE.
    task automatic step(input int st, input logic [5:0] op, input logic rdy);
        @(negedge clk);
        opcode = (st == 2) ? op : 6'($urandom);
        mem_ready = rdy;
        zero = 1'($urandom);
        #1;
        chk("state", 32'(state), 32'(st));
        chk($sformatf("outs_s%0d_op%02h", st, op), 32'(outs), 32'(exp_outs(st, op, zero, rdy)));
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i <= fw; i++) step(1, op, i == fw);
        step(2, op, 1'($urandom));
        if (op == LW || op == SW) begin
            step(3, op, 1'($urandom));
            for (int i = 0; i <= mw; i++) step((op == LW) ? 4 : 6, op, i == mw);
            if (op == LW) step(5, op, 1'($urandom));
        end else if (op == RT) begin
            step(7, op, 1'($urandom));
            step(8, op, 1'($urandom));
        end else if (op == BEQ || op == BNE) begin
            step(9, op, 1'($urandom));
        end else if (op inside {ADDI, ANDI, ORI}) begin
            step(10, op, 1'($urandom));
            step(11, op, 1'($urandom));
        end else if (op == J) begin
            step(12, op, 1'($urandom));
        end
    endtask

    logic [5:0] ops [9] = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, J};

    initial begin
        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'(outs), 32'd0);
        run_instr(RT, 0, 0);
        run_instr(LW, 1, 1);
        repeat (3) begin
            run_instr(BEQ, 0, 0);
            run_instr(BNE, 0, 0);
        end
        run_instr(6'h3f, 0, 0);
        run_instr(ANDI, 0, 0);
        run_instr(ORI, 2, 0);
        run_instr(SW, 0, 3);
        // Reset arriving while a store is still waiting on memory.
        step(1, SW, 1'b1);
        step(2, SW, 1'b1);
        step(3, SW, 1'b1);
        step(6, SW, 1'b0);
        step(6, SW, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("midst_state", 32'(state), 32'd6);
        chk("midst_outs", 32'(outs), 32'(exp_outs(6, SW, zero, 1'b0)));
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("postrst_state", 32'(state), 32'd0);
        chk("postrst_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            automatic logic [5:0] op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            automatic int fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            automatic int mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(op, fw, mw);
        end
        step(1, RT, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
